// File: rtl/csr_ext_arbiter.sv
// csr_ext_arbiter
//   Round-robin arbiter that merges external CSR write requesters onto the
//   table's single external write port. One pending write is held at a time.
//   A core CSR access to the same table index always wins, and the held write
//   stalls until that access moves away.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; transfer on valid && ready
//   req_idx/req_data  per-requester target index and write data
//   core_csr_*        core CSR access this cycle (enable, in-range hit, index)
//   ext_write_enable  write strobe to the table external port
//   ext_idx/ext_data  index and data of the held write
//   ext_grant_id      requester that owns the held write
//   ext_stall         held write blocked by a core conflict this cycle
//   idx_err           one-cycle pulse: an accepted request had an out-of-range
//                     index and was dropped
module csr_ext_arbiter #(
    parameter int  NumReq    = 4,
    parameter int  TableSize = 8,
    parameter type CsrDataT  = logic [31:0],
    localparam int IdxBits   = $clog2(TableSize),
    localparam int GntBits   = $clog2(NumReq)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NumReq-1:0]                 req_valid,
    output logic [NumReq-1:0]                 req_ready,
    input  logic [NumReq-1:0][IdxBits-1:0]    req_idx,
    input  CsrDataT                           req_data [NumReq],
    input  logic                              core_csr_enable,
    input  logic                              core_csr_hit,
    input  logic [IdxBits-1:0]                core_csr_idx,
    output logic                              ext_write_enable,
    output logic [IdxBits-1:0]                ext_idx,
    output CsrDataT                           ext_data,
    output logic [GntBits-1:0]                ext_grant_id,
    output logic                              ext_stall,
    output logic                              idx_err
);

    logic               hold_valid;
    logic [IdxBits-1:0] hold_idx;
    CsrDataT            hold_data;
    logic [GntBits-1:0] hold_id;
    logic [GntBits-1:0] rr_ptr;

    logic               conflict;
    logic               issue;
    logic               slot_open;
    logic               accept;
    logic               win_found;
    logic [GntBits-1:0] win_id;
    logic [GntBits-1:0] next_ptr;
    logic               bad_idx;

    assign conflict  = hold_valid && core_csr_enable && core_csr_hit
                       && (core_csr_idx == hold_idx);
    assign issue     = hold_valid && !conflict;
    // The slot opens when the holding register is empty or drains this cycle,
    // so accepts can run back-to-back at one write per cycle.
    assign slot_open = (!hold_valid || issue) && !reset;
    assign accept    = slot_open && win_found;

    // Rotating search starting at rr_ptr, wrapping NumReq-1 -> 0.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NumReq) cand = cand - NumReq;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = GntBits'(cand);
            end
        end
    end

    assign next_ptr = (win_id == GntBits'(NumReq - 1)) ? '0 : win_id + GntBits'(1);
    assign bad_idx  = int'(req_idx[win_id]) >= TableSize;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
    end

    assign ext_write_enable = issue && !reset;
    assign ext_idx          = hold_idx;
    assign ext_data         = hold_data;
    assign ext_grant_id     = hold_id;
    assign ext_stall        = hold_valid && conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_idx   <= '0;
            hold_data  <= '0;
            hold_id    <= '0;
            rr_ptr     <= '0;
            idx_err    <= 1'b0;
        end else begin
            idx_err <= 1'b0;
            if (accept) begin
                rr_ptr <= next_ptr;
                if (bad_idx) begin
                    // Dropped: the slot was empty or draining, so it ends empty.
                    hold_valid <= 1'b0;
                    idx_err    <= 1'b1;
                end else begin
                    hold_valid <= 1'b1;
                    hold_idx   <= req_idx[win_id];
                    hold_data  <= req_data[win_id];
                    hold_id    <= win_id;
                end
            end else if (issue) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_ext_arbiter.sv
module tb_csr_ext_arbiter;

    localparam int NR = 4;
    localparam int TS = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0][2:0] req_idx;
    logic [31:0]       req_data [NR];
    logic              core_csr_enable;
    logic              core_csr_hit;
    logic [2:0]        core_csr_idx;
    logic              ext_write_enable;
    logic [2:0]        ext_idx;
    logic [31:0]       ext_data;
    logic [1:0]        ext_grant_id;
    logic              ext_stall;
    logic              idx_err;

    always #5 clk = ~clk;

    csr_ext_arbiter #(.NumReq(NR), .TableSize(TS), .CsrDataT(logic [31:0])) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_data(req_data),
        .core_csr_enable(core_csr_enable), .core_csr_hit(core_csr_hit),
        .core_csr_idx(core_csr_idx),
        .ext_write_enable(ext_write_enable), .ext_idx(ext_idx),
        .ext_data(ext_data), .ext_grant_id(ext_grant_id),
        .ext_stall(ext_stall), .idx_err(idx_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the pending write and the requester to search first.
    bit          m_valid;
    int          m_idx;
    logic [31:0] m_data;
    int          m_id;
    int          m_ptr;
    bit          m_err;

    logic [3:0]  obs_ready;
    logic        obs_wen, obs_stall, obs_err;
    logic [2:0]  obs_idx;
    logic [31:0] obs_data;
    logic [1:0]  obs_gid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_data = '0; m_id = 0; m_ptr = 0; m_err = 0;
    endtask

    // One clock cycle: inputs are already driven; check outputs mid-cycle,
    // then advance the model across the rising edge.
    task automatic do_cycle();
        bit         blocked, writes, open;
        int         winner;
        logic [3:0] e_ready;
        #3;
        blocked = m_valid && core_csr_enable && core_csr_hit && (int'(core_csr_idx) == m_idx);
        writes  = m_valid && !blocked;
        open    = !reset && (!m_valid || writes);
        winner  = -1;
        for (int k = 0; k < NR; k++)
            if (winner < 0 && req_valid[(m_ptr + k) % NR]) winner = (m_ptr + k) % NR;
        e_ready = '0;
        if (open && winner >= 0) e_ready[winner] = 1'b1;

        obs_ready = req_ready; obs_wen = ext_write_enable; obs_stall = ext_stall;
        obs_err = idx_err; obs_idx = ext_idx; obs_data = ext_data; obs_gid = ext_grant_id;
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("ext_write_enable", 64'(ext_write_enable), 64'(writes && !reset));
        check("ext_stall", 64'(ext_stall), 64'(blocked));
        check("idx_err", 64'(idx_err), 64'(m_err));
        if (m_valid) begin
            check("ext_idx", 64'(ext_idx), 64'(m_idx));
            check("ext_data", 64'(ext_data), 64'(m_data));
            check("ext_grant_id", 64'(ext_grant_id), 64'(m_id));
        end

        @(posedge clk);
        if (reset) model_reset();
        else begin
            m_err = 0;
            if (open && winner >= 0) begin
                m_ptr = (winner + 1) % NR;
                if (int'(req_idx[winner]) >= TS) begin
                    m_valid = 0; m_err = 1;
                end else begin
                    m_valid = 1; m_idx = int'(req_idx[winner]);
                    m_data = req_data[winner]; m_id = winner;
                end
            end else if (writes) m_valid = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; core_csr_enable = 0; core_csr_hit = 0; core_csr_idx = '0;
        for (int i = 0; i < NR; i++) begin
            req_idx[i] = 3'(i); req_data[i] = 32'h1000 + 32'(i);
        end
    endtask

    initial begin
        reset = 1; idle_inputs();
        @(posedge clk); #1;
        model_reset();
        do_cycle();
        check("reset_ready", 64'(obs_ready), 64'h0);
        check("reset_wen", 64'(obs_wen), 64'h0);
        reset = 0;

        // Single request from requester 1.
        req_valid = 4'b0010; req_idx[1] = 3'd3; req_data[1] = 32'hA5;
        do_cycle();
        check("single_ready", 64'(obs_ready), 64'h2);
        req_valid = '0;
        do_cycle();
        check("single_wen", 64'(obs_wen), 64'h1);
        check("single_idx", 64'(obs_idx), 64'h3);
        check("single_data", 64'(obs_data), 64'hA5);
        check("single_gid", 64'(obs_gid), 64'h1);

        // Conflict on idx 5 for three cycles, then core moves to idx 4.
        req_valid = 4'b0001; req_idx[0] = 3'd5; req_data[0] = 32'h55;
        do_cycle();
        req_valid = 4'b1111; req_idx[0] = 3'd1;
        core_csr_enable = 1; core_csr_hit = 1; core_csr_idx = 3'd5;
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            check("conf_stall", 64'(obs_stall), 64'h1);
            check("conf_wen", 64'(obs_wen), 64'h0);
            check("conf_ready", 64'(obs_ready), 64'h0);
        end
        core_csr_idx = 3'd4;
        do_cycle();
        check("noconf_wen", 64'(obs_wen), 64'h1);
        check("noconf_stall", 64'(obs_stall), 64'h0);
        check("noconf_idx", 64'(obs_idx), 64'h5);
        idle_inputs();
        repeat (2) do_cycle();

        // Out-of-range index from requester 2 (rr_ptr is 2 here).
        req_valid = 4'b0100; req_idx[2] = 3'd7;
        do_cycle();
        check("bad_ready", 64'(obs_ready), 64'h4);
        req_valid = '0; req_idx[2] = 3'd2;
        do_cycle();
        check("bad_err", 64'(obs_err), 64'h1);
        check("bad_wen", 64'(obs_wen), 64'h0);
        do_cycle();
        check("bad_err_clear", 64'(obs_err), 64'h0);
        req_valid = 4'b1111;
        do_cycle();
        check("bad_ptr_adv", 64'(obs_ready), 64'h8);

        // Fairness from reset.
        reset = 1; do_cycle(); reset = 0;
        for (int c = 0; c < 5; c++) begin
            do_cycle();
            check("fair_ready", 64'(obs_ready), 64'(4'b0001 << (c % 4)));
            if (c > 0) begin
                check("fair_wen", 64'(obs_wen), 64'h1);
                check("fair_gid", 64'(obs_gid), 64'((c - 1) % 4));
            end
        end

        // Reset while stalled.
        idle_inputs();
        do_cycle();
        req_valid = 4'b0001; req_idx[0] = 3'd2;
        do_cycle();
        req_valid = '0; core_csr_enable = 1; core_csr_hit = 1; core_csr_idx = 3'd2;
        do_cycle();
        check("rst_stall_pre", 64'(obs_stall), 64'h1);
        reset = 1; do_cycle(); reset = 0;
        idle_inputs();
        do_cycle();
        check("rst_stall_nowrite", 64'(obs_wen), 64'h0);
        req_valid = 4'b1111;
        do_cycle();
        check("rst_stall_ptr0", 64'(obs_ready), 64'h1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            req_valid = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_idx[i]  = 3'($urandom_range(0, 7));
                req_data[i] = $urandom;
            end
            core_csr_enable = $urandom_range(0, 1) == 1;
            core_csr_hit    = $urandom_range(0, 3) != 0;
            core_csr_idx    = ($urandom_range(0, 1) == 1) ? 3'(m_idx) : 3'($urandom_range(0, 7));
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
